// File: rtl/line_server_pkg.sv
// Shared definitions for the line memory server: default geometry and the
// 3-bit state encoding used by the request FSM.
package line_server_pkg;

  localparam int LS_MEMSIZE  = 25;
  localparam int LS_ADDRSIZE = 6;
  localparam int LS_DEPTH    = 64;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t READY = 3'd1;
  localparam state_t FETCH = 3'd2;
  localparam state_t LATCH = 3'd3;
  localparam state_t HOLD  = 3'd4;
  localparam state_t WRITE = 3'd5;

endpackage

// File: rtl/line_index_counter.sv
// Line index counter: synchronous clear, enabled modulo increment and a flag
// marking the final line of a pass.
module line_index_counter #(
  parameter int addrsize = 6,
  parameter int DEPTH    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_zero_i,
  input  logic                en_i,
  output logic [addrsize-1:0] count_o,
  output logic                last_o
);

  localparam logic [addrsize-1:0] LAST_IDX = addrsize'(DEPTH - 1);

  logic [addrsize-1:0] count_q, count_d, count_inc;
  logic                carry_unused;

  // The carry out of the increment is deliberately dropped: the index wraps.
  assign {carry_unused, count_inc} = {1'b0, count_q} + {{addrsize{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (load_zero_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/line_memory_server.sv
// Memory-side responder: walks line indices in order, fetches each line,
// holds it for the controller and writes the processed line back in place.
module line_memory_server
  import line_server_pkg::*;
#(
  parameter int memsize  = LS_MEMSIZE,
  parameter int addrsize = LS_ADDRSIZE,
  parameter int DEPTH    = LS_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                readLine,
  input  logic                writeVal,
  input  logic [memsize-1:0]  wdata,
  output logic [memsize-1:0]  line,
  output logic                lineValid,
  output logic [addrsize-1:0] count,
  output logic                done,
  output logic [addrsize-1:0] memAddr,
  output logic                memRead,
  output logic                memWrite,
  output logic [memsize-1:0]  memWData,
  input  logic [memsize-1:0]  memRData
);

  state_t              state_q, state_d;
  logic [memsize-1:0]  line_q, line_d;
  logic [memsize-1:0]  wreg_q, wreg_d;
  logic                done_q, done_d;
  logic [addrsize-1:0] count_w;
  logic                last_w;
  logic                accept_start;

  assign accept_start = (state_q == IDLE) && start;

  line_index_counter #(
    .addrsize(addrsize),
    .DEPTH   (DEPTH)
  ) u_index (
    .clk        (clk),
    .rst        (rst),
    .load_zero_i(accept_start),
    .en_i       (state_q == WRITE),
    .count_o    (count_w),
    .last_o     (last_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // writeVal is only examined in HOLD, so it beats a coincident readLine there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = READY;
      READY:   if (readLine) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = HOLD;
      HOLD:    if (writeVal) state_d = WRITE;
      WRITE:   state_d = last_w ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = line_q;
    wreg_d = wreg_q;
    done_d = done_q;
    if (accept_start)                    done_d = 1'b0;
    if (state_q == LATCH)                line_d = memRData;
    if ((state_q == HOLD) && writeVal)   wreg_d = wdata;
    if ((state_q == WRITE) && last_w)    done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      wreg_q <= '0;
      done_q <= 1'b0;
    end else begin
      line_q <= line_d;
      wreg_q <= wreg_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    lineValid = 1'b0;
    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        memAddr = count_w;
      end
      HOLD: lineValid = 1'b1;
      WRITE: begin
        memWrite = 1'b1;
        memAddr  = count_w;
        memWData = wreg_q;
      end
      default: ;
    endcase
  end

  assign line  = line_q;
  assign count = count_w;
  assign done  = done_q;

endmodule
